// File: rtl/encoder_8_3_stream.sv
// ---------------------------------------------------------------------------
// encoder_8_3_stream
//
// Streaming 8-to-3 encoder on the return path of a valid/ready stream.
// It turns a one-hot byte back into its 3-bit index {A,B,C}, so feeding it
// the output of the 3-8 decoder returns the original value. Words that are
// not exactly one-hot are still encoded (zero -> 000; multi-hot -> highest or
// lowest set bit, chosen by PRIORITY_HIGH), are flagged with ERR, and are
// counted in a saturating error counter.
//
// A 2-entry skid buffer (head = output register, skid = second entry)
// decouples the two handshakes. This lets IN_READY come straight from a flop
// while the block still sustains one word per cycle.
//
// Parameters
//   PRIORITY_HIGH  1: highest set bit wins on multi-hot, 0: lowest wins
//   CNT_W          width of ERR_CNT
//
// Ports
//   CLK         clock, rising edge
//   RST_N       asynchronous active-low reset (release synchronous to CLK)
//   IN[7:0]     one-hot word, bit i set encodes value i
//   IN_VALID    IN carries a word this cycle
//   IN_READY    block can take a word (registered)
//   A, B, C     encoded index of the head word, A is the MSB
//   ERR         head word was not exactly one-hot
//   CODE_VALID  A/B/C/ERR hold a word
//   CODE_READY  downstream takes the head word this cycle
//   CLR_CNT     synchronous clear of ERR_CNT (wins over an increment)
//   ERR_CNT     saturating count of accepted erroneous words
// ---------------------------------------------------------------------------
module encoder_8_3_stream #(
    parameter bit PRIORITY_HIGH = 1'b1,
    parameter int CNT_W         = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [7:0]       IN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic             A,
    output logic             B,
    output logic             C,
    output logic             ERR,
    output logic             CODE_VALID,
    input  logic             CODE_READY,
    input  logic             CLR_CNT,
    output logic [CNT_W-1:0] ERR_CNT
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // Returns {err, index}. The index follows the configured priority when
    // more than one bit is set, and is 000 for an all-zero word.
    function automatic logic [3:0] encode_word(input logic [7:0] w);
        logic [2:0] idx;
        logic       one_hot;
        idx = 3'd0;
        if (PRIORITY_HIGH) begin
            for (int i = 0; i < 8; i++) begin
                if (w[i]) idx = i[2:0];
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (w[i]) idx = i[2:0];
            end
        end
        // A word is one-hot when it is non-zero and clearing its lowest set
        // bit leaves nothing behind.
        one_hot = (w != 8'd0) && ((w & (w - 8'd1)) == 8'd0);
        return {~one_hot, idx};
    endfunction

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) return v;
        return v + 1'b1;
    endfunction

    state_t           state;
    state_t           state_next;
    logic             in_ready_r;
    logic             code_valid;
    logic             accept;
    logic             pop;
    logic             load_head;
    logic             load_skid;
    logic             head_from_skid;

    logic [7:0]       in_masked;
    logic [3:0]       enc_p0;
    logic [2:0]       head_code;
    logic             head_err;
    logic [2:0]       skid_code;
    logic             skid_err;
    logic [CNT_W-1:0] err_cnt;

    // ---- input stage: handshake and encode at accept time ----
    assign code_valid = (state != EMPTY);
    assign accept     = IN_VALID & in_ready_r;
    assign pop        = code_valid & CODE_READY;

    // Masking with IN_VALID keeps an undriven IN from reaching the encoder;
    // the buffer loads are additionally gated by accept.
    assign in_masked  = IN & {8{IN_VALID}};
    assign enc_p0     = encode_word(in_masked);

    // Buffer control. The skid is only ever written from ONE while the head
    // is stalled, and the head refills from the skid when it drains in TWO.
    always_comb begin
        state_next     = state;
        load_head      = 1'b0;
        load_skid      = 1'b0;
        head_from_skid = 1'b0;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    state_next = ONE;
                    load_head  = 1'b1;
                end
            end
            ONE: begin
                if (accept && !pop) begin
                    state_next = TWO;
                    load_skid  = 1'b1;
                end else if (pop && !accept) begin
                    state_next = EMPTY;
                end else if (accept && pop) begin
                    state_next = ONE;
                    load_head  = 1'b1;
                end
            end
            TWO: begin
                // IN_READY is low here, so accept cannot occur.
                if (pop) begin
                    state_next     = ONE;
                    head_from_skid = 1'b1;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    // ---- output stage: head register, control state, error counter ----
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= EMPTY;
            in_ready_r <= 1'b0;
            head_code  <= 3'd0;
            head_err   <= 1'b0;
            err_cnt    <= '0;
        end else begin
            state      <= state_next;
            // Ready is decided from the next state so it lines up with the
            // buffer occupancy seen in the following cycle.
            in_ready_r <= (state_next != TWO);

            if (load_head) begin
                head_code <= enc_p0[2:0];
                head_err  <= enc_p0[3];
            end else if (head_from_skid) begin
                head_code <= skid_code;
                head_err  <= skid_err;
            end

            if (CLR_CNT) begin
                err_cnt <= '0;
            end else if (accept && enc_p0[3]) begin
                err_cnt <= sat_inc(err_cnt);
            end
        end
    end

    // Skid entry is pure data: its content is meaningless unless the state
    // says TWO, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (load_skid) begin
            skid_code <= enc_p0[2:0];
            skid_err  <= enc_p0[3];
        end
    end

    assign IN_READY   = in_ready_r;
    assign CODE_VALID = code_valid;
    assign A          = head_code[2];
    assign B          = head_code[1];
    assign C          = head_code[0];
    assign ERR        = head_err;
    assign ERR_CNT    = err_cnt;

endmodule

// File: tb/tb_encoder_8_3_stream.sv
// ---------------------------------------------------------------------------
// tb_encoder_8_3_stream
//
// Bench for encoder_8_3_stream. Three instances share one input stream:
//   u_h : PRIORITY_HIGH=1, CNT_W=8
//   u_l : PRIORITY_HIGH=0, CNT_W=8
//   u_c : PRIORITY_HIGH=1, CNT_W=2
// A queue model of the stream (words in flight, error tally) predicts every
// output on each falling edge. Directed tests also check logged output
// sequences and counter values against hand-computed literals.
// ---------------------------------------------------------------------------
module tb_encoder_8_3_stream;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [7:0] IN;
    logic       IN_VALID;
    logic       CODE_READY;
    logic       CLR_CNT;

    logic       rdy_h, a_h, b_h, c_h, err_h, vld_h;
    logic [7:0] cnt_h;
    logic       rdy_l, a_l, b_l, c_l, err_l, vld_l;
    logic [7:0] cnt_l;
    logic       rdy_c, a_c, b_c, c_c, err_c, vld_c;
    logic [1:0] cnt_c;

    encoder_8_3_stream #(.PRIORITY_HIGH(1'b1), .CNT_W(8)) u_h (
        .CLK(CLK), .RST_N(RST_N), .IN(IN), .IN_VALID(IN_VALID), .IN_READY(rdy_h),
        .A(a_h), .B(b_h), .C(c_h), .ERR(err_h), .CODE_VALID(vld_h),
        .CODE_READY(CODE_READY), .CLR_CNT(CLR_CNT), .ERR_CNT(cnt_h)
    );

    encoder_8_3_stream #(.PRIORITY_HIGH(1'b0), .CNT_W(8)) u_l (
        .CLK(CLK), .RST_N(RST_N), .IN(IN), .IN_VALID(IN_VALID), .IN_READY(rdy_l),
        .A(a_l), .B(b_l), .C(c_l), .ERR(err_l), .CODE_VALID(vld_l),
        .CODE_READY(CODE_READY), .CLR_CNT(CLR_CNT), .ERR_CNT(cnt_l)
    );

    encoder_8_3_stream #(.PRIORITY_HIGH(1'b1), .CNT_W(2)) u_c (
        .CLK(CLK), .RST_N(RST_N), .IN(IN), .IN_VALID(IN_VALID), .IN_READY(rdy_c),
        .A(a_c), .B(b_c), .C(c_c), .ERR(err_c), .CODE_VALID(vld_c),
        .CODE_READY(CODE_READY), .CLR_CNT(CLR_CNT), .ERR_CNT(cnt_c)
    );

    always #5 CLK = ~CLK;

    int         total = 0;
    int         bad   = 0;

    // Model state: raw words in flight, error words since last clear, and
    // whether the first clock after reset release has happened.
    logic [7:0] mq[$];
    int         err_seen = 0;
    bit         rdy_en   = 1'b0;

    logic [3:0] log_h[$];
    logic [3:0] log_l[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected {err, index} from arithmetic on the word itself.
    function automatic logic [3:0] model_enc(input logic [7:0] w, input bit high);
        int         v;
        int         idx;
        logic [2:0] code;
        logic       err;
        v   = int'(w);
        err = ($countones(w) != 1);
        if (v == 0)    idx = 0;
        else if (high) idx = $clog2(v + 1) - 1;
        else           idx = $clog2(v & -v);
        code = idx[2:0];
        return {err, code};
    endfunction

    function automatic int sat(input int n, input int w);
        int m;
        m = (1 << w) - 1;
        return (n > m) ? m : n;
    endfunction

    // Model update on each rising edge, using the occupancy before the edge.
    always @(posedge CLK) begin
        bit acc;
        bit pp;
        if (!RST_N) begin
            rdy_en = 1'b0;
        end else begin
            acc = IN_VALID && rdy_en && (mq.size() < 2);
            pp  = (mq.size() > 0) && CODE_READY;
            if (pp) void'(mq.pop_front());
            if (acc) mq.push_back(IN);
            if (CLR_CNT) err_seen = 0;
            else if (acc && ($countones(IN) != 1)) err_seen++;
            rdy_en = 1'b1;
        end
    end

    always @(negedge RST_N) begin
        mq.delete();
        err_seen = 0;
        rdy_en   = 1'b0;
    end

    task automatic chk_dut(input string tag, input logic rdy, input logic vld,
                           input logic [2:0] code, input logic err, input int cnt,
                           input bit high, input int cw);
        logic [3:0] e;
        if (!RST_N) begin
            chk({tag, "_rst_ready"}, int'(rdy), 0);
            chk({tag, "_rst_valid"}, int'(vld), 0);
            chk({tag, "_rst_code"},  int'(code), 0);
            chk({tag, "_rst_err"},   int'(err), 0);
            chk({tag, "_rst_cnt"},   cnt, 0);
        end else begin
            chk({tag, "_ready"}, int'(rdy), int'(rdy_en && (mq.size() < 2)));
            chk({tag, "_valid"}, int'(vld), int'(mq.size() > 0));
            if (mq.size() > 0) begin
                e = model_enc(mq[0], high);
                chk({tag, "_code"}, int'(code), int'(e[2:0]));
                chk({tag, "_err"},  int'(err),  int'(e[3]));
            end
            chk({tag, "_cnt"}, cnt, sat(err_seen, cw));
        end
    endtask

    // Per-cycle compare, plus a log of every word the DUT hands downstream.
    always @(negedge CLK) begin
        chk_dut("h", rdy_h, vld_h, {a_h, b_h, c_h}, err_h, int'(cnt_h), 1'b1, 8);
        chk_dut("l", rdy_l, vld_l, {a_l, b_l, c_l}, err_l, int'(cnt_l), 1'b0, 8);
        chk_dut("c", rdy_c, vld_c, {a_c, b_c, c_c}, err_c, int'(cnt_c), 1'b1, 2);
        if (RST_N && vld_h && CODE_READY) log_h.push_back({err_h, a_h, b_h, c_h});
        if (RST_N && vld_l && CODE_READY) log_l.push_back({err_l, a_l, b_l, c_l});
    end

    task automatic chk_log(input string name, input logic [3:0] got[$], input logic [3:0] exp[$]);
        chk({name, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            chk({name, "_item"}, (i < got.size()) ? int'(got[i]) : -1, int'(exp[i]));
        end
    endtask

    // Called just after a rising edge: drive inputs, run one clock.
    task automatic step(input logic [7:0] w, input logic v, input logic r, input logic c);
        IN         = v ? w : 8'hxx;
        IN_VALID   = v;
        CODE_READY = r;
        CLR_CNT    = c;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [3:0] exp_q[$];
        int         ce[5];
        ce = '{1, 2, 3, 3, 3};

        RST_N = 1'b1; IN = 8'h00; IN_VALID = 1'b0; CODE_READY = 1'b0; CLR_CNT = 1'b0;
        #1 RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #3;
        chk("rst_ready", int'(rdy_h), 0);
        chk("rst_valid", int'(vld_h), 0);
        chk("rst_code",  int'({a_h, b_h, c_h}), 0);
        chk("rst_cnt",   int'(cnt_h), 0);
        @(negedge CLK);
        #1 RST_N = 1'b1;
        @(posedge CLK);
        #1;
        chk("release_ready", int'(rdy_h), 1);
        chk("release_valid", int'(vld_h), 0);

        // Round trip of all eight decoder outputs, back-to-back.
        log_h.delete(); log_l.delete();
        for (int i = 0; i < 8; i++) step(8'(1 << i), 1'b1, 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b1, 1'b0);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(4'(i));
        chk_log("roundtrip", log_h, exp_q);
        chk("roundtrip_cnt", int'(cnt_h), 0);

        // Zero and multi-hot words; {err,code} 8 = err/000, 15 = err/111, 12 = err/100.
        log_h.delete(); log_l.delete();
        step(8'h00, 1'b1, 1'b1, 1'b0);
        step(8'h90, 1'b1, 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b1, 1'b0);
        exp_q = '{4'd8, 4'd15};
        chk_log("err_high", log_h, exp_q);
        exp_q = '{4'd8, 4'd12};
        chk_log("err_low", log_l, exp_q);
        chk("err_cnt", int'(cnt_h), 2);

        // Backpressure: two words fill the buffer, the third waits.
        log_h.delete(); log_l.delete();
        step(8'h02, 1'b1, 1'b0, 1'b0);
        step(8'h08, 1'b1, 1'b0, 1'b0);
        chk("bp_ready_low", int'(rdy_h), 0);
        step(8'h20, 1'b1, 1'b0, 1'b0);
        chk("bp_hold", int'({a_h, b_h, c_h}), 1);
        step(8'h20, 1'b1, 1'b0, 1'b0);
        chk("bp_hold", int'({a_h, b_h, c_h}), 1);
        step(8'h20, 1'b1, 1'b1, 1'b0);
        step(8'h20, 1'b1, 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b1, 1'b0);
        exp_q = '{4'd1, 4'd3, 4'd5};
        chk_log("bp_order", log_h, exp_q);

        // Sustained accept-and-pop.
        log_h.delete(); log_l.delete();
        for (int i = 0; i < 16; i++) begin
            step(8'(1 << (i % 8)), 1'b1, 1'b1, 1'b0);
            chk("tp_ready", int'(rdy_h), 1);
        end
        step(8'h00, 1'b0, 1'b1, 1'b0);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(4'(i % 8));
        chk_log("throughput", log_h, exp_q);

        // Saturation of the 2-bit counter, then clear racing an increment.
        step(8'h00, 1'b0, 1'b1, 1'b1);
        chk("cnt_cleared", int'(cnt_c), 0);
        for (int k = 0; k < 5; k++) begin
            step(8'h00, 1'b1, 1'b1, 1'b0);
            chk("cnt_sat", int'(cnt_c), ce[k]);
        end
        chk("cnt_wide", int'(cnt_h), 5);
        step(8'h00, 1'b1, 1'b1, 1'b1);
        chk("cnt_clr_wins", int'(cnt_c), 0);
        chk("cnt_clr_wins_wide", int'(cnt_h), 0);
        step(8'h00, 1'b0, 1'b1, 1'b0);

        // Reset while the buffer is full.
        step(8'h02, 1'b1, 1'b0, 1'b0);
        step(8'h00, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_ready", int'(rdy_h), 0);
        chk("pre_rst_cnt", int'(cnt_h), 1);
        #2;
        RST_N    = 1'b0;
        IN_VALID = 1'b0;
        #1;
        chk("mid_rst_valid", int'(vld_h), 0);
        chk("mid_rst_ready", int'(rdy_h), 0);
        chk("mid_rst_code",  int'({a_h, b_h, c_h}), 0);
        chk("mid_rst_cnt",   int'(cnt_h), 0);
        chk("mid_rst_cnt_c", int'(cnt_c), 0);
        @(posedge CLK);
        @(negedge CLK);
        #1 RST_N = 1'b1;
        @(posedge CLK);
        #1;
        chk("post_rst_ready", int'(rdy_h), 1);
        chk("post_rst_valid", int'(vld_h), 0);
        for (int i = 0; i < 3; i++) begin
            step(8'h00, 1'b0, 1'b1, 1'b0);
            chk("post_rst_idle", int'(vld_h), 0);
        end
        log_h.delete(); log_l.delete();
        step(8'h40, 1'b1, 1'b1, 1'b0);
        chk("post_rst_new", int'(vld_h), 1);
        step(8'h00, 1'b0, 1'b1, 1'b0);
        exp_q = '{4'd6};
        chk_log("post_rst", log_h, exp_q);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
